mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Sequences data-memory loads and stores for the RV32I core against a handshaked data memory (req/gnt, then rvalid for read data).
- Builds byte strobes and lane-replicated write data, and aligns and sign/zero-extends load data.
- Stalls the core until each access completes, and flags misaligned, illegal or timed-out accesses.
- Sits between the decode stage (Load/Store/fun3) plus ALU address, and the data memory port.

Parameters:
- TIMEOUT, 16, max cycles spent in REQ+WAIT before abort (must be >= 2).
- CNT_W, 5, counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  decoded load instruction this cycle.
- store  in  1  decoded store instruction this cycle.
- fun3  in  3  width/sign code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- addr  in  32  effective byte address from ALU.
- wdata  in  32  store data (rs2).
- stall  out  1  hold PC and pipeline while high.
- ld_data  out  32  formatted load result, held until next completed load.
- ld_valid  out  1  one-cycle pulse when ld_data updates.
- misalign_err  out  1  one-cycle pulse on misaligned access.
- access_err  out  1  one-cycle pulse on illegal fun3 or load&store both high.
- bus_err  out  1  one-cycle pulse on timeout.
- mem_req  out  1  request valid.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address, {addr[31:2],2'b00}.
- mem_wstrb  out  4  byte enables (0000 on reads).
- mem_wdata  out  32  lane-replicated write data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data word.

Behaviour:
- Reset (async):
  - state=IDLE, counter=0.
  - All outputs 0 (ld_data=0, stall=0, mem_req=0).
  - Reset mid-access drops mem_req immediately and discards the access.
- States: IDLE, REQ, WAIT, DONE.
- IDLE, on load|store:
  - Legality check, checked in this order:
    - load&store both high -> access_err.
    - Loads legal only for fun3 000,001,010,100,101; stores only for 000,001,010; anything else -> access_err.
    - Halfword with addr[0]=1, or word with addr[1:0]!=0 -> misalign_err.
  - On any error: pulse the error in the same cycle (combinational), no request, stall=0, stay IDLE.
  - If legal: stall=1 (combinational), latch addr/fun3/we/strobe/wdata, go REQ.
- REQ:
  - mem_req=1, stall=1; address, we, strobe and wdata held stable until gnt.
  - On gnt: store -> DONE; load -> WAIT.
- WAIT:
  - stall=1, mem_req=0.
  - On rvalid: format data into ld_data, go DONE.
  - rvalid and gnt are ignored in every other state.
- DONE:
  - stall=0 for exactly one cycle; ld_valid pulses here for loads.
  - load/store inputs are ignored this cycle; return to IDLE.
- Timeout:
  - Counter clears on entry to REQ and increments each cycle in REQ/WAIT.
  - When counter==TIMEOUT-1 without completion: pulse bus_err, drop mem_req, go DONE with ld_valid=0 and ld_data unchanged.
  - Completion in the same cycle as expiry wins; no error.
- Strobes:
  - sb: 0001<<addr[1:0].
  - sh: 0011<<{addr[1],1'b0}.
  - sw: 1111.
- Write data:
  - sb: byte replicated x4.
  - sh: halfword replicated x2.
  - sw: unchanged.
- Load formatting: select the byte at addr[1:0] or the halfword at addr[1].
  - lb/lh: sign-extend to 32.
  - lbu/lhu: zero-extend to 32.
  - lw: full word.
- Latency: minimum store 3 cycles (IDLE, REQ with gnt, DONE) with 2 stall cycles; minimum load 4 cycles.

Decomposition:
- Shared package holds:
  - fun3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - The state enum.
  - Strobe constants.
- One natural combinational sub-module, load_formatter (rdata, offset, fun3 -> ld_data), reusable by a later pipelined LSU.

Test Plan:
- sb, addr=0x103, wdata=0xA5, gnt in the first REQ cycle -> mem_addr=0x100, wstrb=1000, mem_wdata=0xA5A5A5A5, stall high 2 cycles, no errors.
- lb, addr=0x202, rdata=0x0080FF00, gnt after 2 cycles, rvalid 1 cycle later -> ld_data=0xFFFFFF80, ld_valid one pulse in DONE.
- lhu, addr=0x202, rdata=0x8001_0000 -> ld_data=0x00008001; repeat as lh -> 0xFFFF8001.
- lw, addr=0x301 -> misalign_err pulse in the same cycle, mem_req never asserted, stall=0; fun3=011 load -> access_err.
- Load with gnt held low, TIMEOUT=16 -> bus_err pulse at cycle 16 after REQ entry, mem_req drops, one DONE cycle, ld_data unchanged.
- Assert rst_n=0 during WAIT -> mem_req/stall to 0 immediately, state IDLE; a late rvalid after reset is ignored.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller.
// Holds the fun3 width/sign encodings, the sequencing FSM state type and the
// base byte-strobe patterns used when building store byte enables.
package mem_access_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

endpackage

// File: rtl/mem_access_ctrl_load_formatter.sv
// Load data formatter: selects the addressed byte/halfword from a memory word
// and sign- or zero-extends it to 32 bits.
// Ports:
//   i_rdata  [31:0] raw word from data memory
//   i_offset [1:0]  byte offset within the word (addr[1:0])
//   i_fun3   [2:0]  width/sign code
//   o_data   [31:0] formatted load result
module load_formatter
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_fun3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = '0;
    case (i_offset)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

    o_data = i_rdata;
    case (i_fun3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'd0, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'd0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory load/store sequencer for the RV32I core.
// Checks legality/alignment of decoded loads and stores, issues one req/gnt
// transaction (plus rvalid for reads), stalls the core until completion, and
// aborts with bus_err after TIMEOUT cycles in REQ/WAIT.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   load, store, fun3, addr, wdata   decode/ALU request
//   stall                       hold pipeline
//   ld_data, ld_valid           formatted load result and update pulse
//   misalign_err, access_err, bus_err   one-cycle error pulses
//   mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, mem_gnt,
//   mem_rvalid, mem_rdata       data memory port
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        store,
  input  logic [2:0]  fun3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        misalign_err,
  output logic        access_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_addr;
  logic [2:0]       r_fun3;
  logic             r_we;
  logic [3:0]       r_strb;
  logic [31:0]      r_wdata;
  logic [31:0]      r_ld_data;
  logic             r_ld_valid;

  logic        w_idle_req;
  logic        w_f3_ok;
  logic        w_access;
  logic        w_misalign;
  logic        w_start;
  logic [3:0]  w_strb;
  logic [31:0] w_wdata;
  logic        w_complete;
  logic        w_timeout;
  logic [31:0] w_fmt;

  always_comb begin
    w_idle_req = (r_state == S_IDLE) && (load || store);
    if (load)
      w_f3_ok = (fun3 == F3_B) || (fun3 == F3_H) || (fun3 == F3_W) ||
                (fun3 == F3_BU) || (fun3 == F3_HU);
    else
      w_f3_ok = (fun3 == F3_B) || (fun3 == F3_H) || (fun3 == F3_W);

    // Alignment is only reported once the access is otherwise legal.
    w_access   = w_idle_req && ((load && store) || !w_f3_ok);
    w_misalign = w_idle_req && !w_access &&
                 (((fun3[1:0] == 2'b01) && addr[0]) ||
                  ((fun3[1:0] == 2'b10) && (addr[1:0] != 2'b00)));
    w_start    = w_idle_req && !w_access && !w_misalign;

    w_strb  = '0;
    w_wdata = wdata;
    if (store) begin
      case (fun3[1:0])
        2'b00:   begin
          w_strb  = STRB_B << addr[1:0];
          w_wdata = {4{wdata[7:0]}};
        end
        2'b01:   begin
          w_strb  = STRB_H << {addr[1], 1'b0};
          w_wdata = {2{wdata[15:0]}};
        end
        default: w_strb = STRB_W;
      endcase
    end

    w_complete = ((r_state == S_REQ) && mem_gnt && r_we) ||
                 ((r_state == S_WAIT) && mem_rvalid);
    w_timeout  = ((r_state == S_REQ) || (r_state == S_WAIT)) &&
                 (r_cnt == CNT_W'(TIMEOUT - 1)) && !w_complete;
  end

  load_formatter u_fmt (
    .i_rdata  (mem_rdata),
    .i_offset (r_addr[1:0]),
    .i_fun3   (r_fun3),
    .o_data   (w_fmt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_fun3     <= '0;
      r_we       <= 1'b0;
      r_strb     <= '0;
      r_wdata    <= '0;
      r_ld_data  <= '0;
      r_ld_valid <= 1'b0;
    end else begin
      r_ld_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_addr  <= addr;
            r_fun3  <= fun3;
            r_we    <= store;
            r_strb  <= w_strb;
            r_wdata <= w_wdata;
            r_cnt   <= '0;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_timeout)
            r_state <= S_DONE;
          else if (mem_gnt)
            r_state <= r_we ? S_DONE : S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (mem_rvalid) begin
            r_ld_data  <= w_fmt;
            r_ld_valid <= 1'b1;
            r_state    <= S_DONE;
          end else if (w_timeout) begin
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall        = w_start || (r_state == S_REQ) || (r_state == S_WAIT);
  assign misalign_err = w_misalign;
  assign access_err   = w_access;
  assign bus_err      = w_timeout;
  assign ld_data      = r_ld_data;
  assign ld_valid     = r_ld_valid;
  assign mem_req      = (r_state == S_REQ);
  assign mem_we       = (r_state == S_REQ) && r_we;
  assign mem_addr     = {r_addr[31:2], 2'b00};
  assign mem_wstrb    = (r_state == S_REQ) ? r_strb : 4'b0000;
  assign mem_wdata    = r_wdata;

endmodule
